// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : dm_pkg                                                     |
// | Shared codes and state encoding for the data-memory block mover.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dm_pkg;

    // Operation codes
    localparam logic [1:0] MODE_FILL = 2'b00;
    localparam logic [1:0] MODE_CPW  = 2'b01;
    localparam logic [1:0] MODE_CPB  = 2'b10;
    localparam logic [1:0] MODE_RSV  = 2'b11;

    // Memory access-type codes
    localparam logic [1:0] BX_LBU = 2'b00;
    localparam logic [1:0] BX_LBS = 2'b01;
    localparam logic [1:0] BX_SB  = 2'b10;
    localparam logic [1:0] BX_W   = 2'b11;

    // Write-enable codes
    localparam logic [1:0] WEN_WR   = 2'b01;
    localparam logic [1:0] WEN_IDLE = 2'b00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        FIN  = 3'd4
    } state_t;

    // A request is refused for the reserved mode, or when a word mode
    // is given an address that is not word aligned.
    function automatic logic req_rejected(input logic [1:0] mode,
                                          input logic [1:0] src_lsb,
                                          input logic [1:0] dst_lsb);
        logic word_mode;
        word_mode = (mode == MODE_FILL) || (mode == MODE_CPW);
        return (mode == MODE_RSV)
            || (word_mode && (dst_lsb != 2'b00))
            || ((mode == MODE_CPW) && (src_lsb != 2'b00));
    endfunction

    // Read access type for a copy mode
    function automatic logic [1:0] load_ext(input logic [1:0] mode);
        return (mode == MODE_CPB) ? BX_LBU : BX_W;
    endfunction

    // Write access type for a copy mode
    function automatic logic [1:0] store_ext(input logic [1:0] mode);
        return (mode == MODE_CPB) ? BX_SB : BX_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_block_mover_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : dm_block_mover_if                                        |
// | Data-memory port: byte address, write data, access type, write       |
// | enable and combinational read data.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dm_block_mover_if #(
    parameter int AW = 12,
    parameter int DW = 32
) ();
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [1:0]    m_byteExt;
    logic [1:0]    m_wEn;
    logic [DW-1:0] m_dout;

    // Bus initiator side
    modport master (
        output m_addr,
        output m_din,
        output m_byteExt,
        output m_wEn,
        input  m_dout
    );

    // Memory side
    modport slave (
        input  m_addr,
        input  m_din,
        input  m_byteExt,
        input  m_wEn,
        output m_dout
    );
endinterface
`default_nettype wire

// File: rtl/dm_block_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_block_mover                                             |
// | Bus initiator for the 4 KB data memory: word fill, word copy and     |
// | byte copy without CPU involvement. All memory-port outputs are       |
// | registered and change only with the state machine.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dm_block_mover
    import dm_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int LW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [LW-1:0]    len,
    input  logic [DW-1:0]    fill_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    dm_block_mover_if.master mem
);

    state_t        state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] remaining;
    logic [1:0]    mode_q;
    logic [DW-1:0] data_buf;     // copy buffer, or the fill pattern in FILL
    logic [AW-1:0] addr_q;
    logic [1:0]    bx_q;
    logic [1:0]    wen_q;

    logic [AW-1:0] step;
    logic          last;
    logic [DW-1:0] rd_capture;

    assign step       = (mode_q == MODE_CPB) ? AW'(1) : AW'(4);
    assign last       = (remaining == LW'(1));
    // Byte copy keeps only the loaded byte, zero-extended; the store
    // writes din[7:0] so the upper bits never reach memory.
    assign rd_capture = (mode_q == MODE_CPB) ? {{(DW-8){1'b0}}, mem.m_dout[7:0]}
                                             : mem.m_dout;

    assign mem.m_addr    = addr_q;
    assign mem.m_din     = data_buf;
    assign mem.m_byteExt = bx_q;
    assign mem.m_wEn     = wen_q;

    // Control FSM with address counters, buffer and registered port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            mode_q    <= MODE_FILL;
            data_buf  <= '0;
            addr_q    <= '0;
            bx_q      <= BX_W;
            wen_q     <= WEN_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wen_q <= WEN_IDLE;
                    bx_q  <= BX_W;
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= len;
                        mode_q    <= mode;
                        busy      <= 1'b1;
                        if (req_rejected(mode, src_addr[1:0], dst_addr[1:0])) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (mode == MODE_FILL) begin
                            state    <= FILL;
                            addr_q   <= dst_addr;
                            data_buf <= fill_val;
                            wen_q    <= WEN_WR;
                        end else begin
                            state  <= RD;
                            addr_q <= src_addr;
                            bx_q   <= load_ext(mode);
                        end
                    end
                end

                RD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        bx_q  <= BX_W;
                    end else begin
                        state    <= WR;
                        data_buf <= rd_capture;
                        addr_q   <= dst;
                        bx_q     <= store_ext(mode_q);
                        wen_q    <= WEN_WR;
                    end
                end

                WR: begin
                    src       <= src + step;
                    dst       <= dst + step;
                    remaining <= remaining - LW'(1);
                    wen_q     <= WEN_IDLE;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        bx_q  <= BX_W;
                    end else if (last) begin
                        state <= FIN;
                        done  <= 1'b1;
                        bx_q  <= BX_W;
                    end else begin
                        state  <= RD;
                        addr_q <= src + step;
                        bx_q   <= load_ext(mode_q);
                    end
                end

                FILL: begin
                    dst       <= dst + step;
                    remaining <= remaining - LW'(1);
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        wen_q <= WEN_IDLE;
                    end else if (last) begin
                        state <= FIN;
                        done  <= 1'b1;
                        wen_q <= WEN_IDLE;
                    end else begin
                        addr_q <= dst + step;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wen_q <= WEN_IDLE;
                    bx_q  <= BX_W;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wen_q <= WEN_IDLE;
                    bx_q  <= BX_W;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_block_mover.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_dm_block_mover                                          |
// | Bench for dm_block_mover with a behavioural 4 KB memory and a        |
// | whole-operation reference model.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dm_block_mover;
    import dm_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [AW-1:0] src_i = '0;
    logic [AW-1:0] dst_i = '0;
    logic [LW-1:0] len_i = '0;
    logic [DW-1:0] fill_i = '0;
    logic          abort = 1'b0;
    logic          busy, done, err;

    dm_block_mover_if #(.AW(AW), .DW(DW)) mem_if ();

    dm_block_mover #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode_i),
        .src_addr (src_i),
        .dst_addr (dst_i),
        .len      (len_i),
        .fill_val (fill_i),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural dm_4k ----------------
    logic [31:0] ram [0:1023];
    logic [31:0] exp_ram [0:1023];
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int off);
        return w[8*(3-off) +: 8];
    endfunction

    // combinational read port
    always_comb begin
        rd_word = ram[mem_if.m_addr[11:2]];
        rd_byte = byte_of(rd_word, int'(mem_if.m_addr[1:0]));
        case (mem_if.m_byteExt)
            BX_LBU:  mem_if.m_dout = {24'h0, rd_byte};
            BX_LBS:  mem_if.m_dout = {{24{rd_byte[7]}}, rd_byte};
            default: mem_if.m_dout = rd_word;
        endcase
    end

    // clocked write port, plus a backdoor for preloading
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_idx] <= bd_val;
        end else if (mem_if.m_wEn == WEN_WR) begin
            if (mem_if.m_byteExt == BX_W)
                ram[mem_if.m_addr[11:2]] <= mem_if.m_din;
            else if (mem_if.m_byteExt == BX_SB)
                ram[mem_if.m_addr[11:2]][8*(3-int'(mem_if.m_addr[1:0])) +: 8] <= mem_if.m_din[7:0];
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 10'(idx); bd_val = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 1024; i++) exp_ram[i] = ram[i];
    endtask

    task automatic compare_mem(input string name);
        int diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== exp_ram[i]) diffs++;
        check(name, 64'(diffs), 64'd0);
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_reject(input int md, input int s, input int d);
        if (md == 3) return 1'b1;
        if (md == 0) return (d % 4) != 0;
        if (md == 1) return ((d % 4) != 0) || ((s % 4) != 0);
        return 1'b0;
    endfunction

    // Whole operation applied to exp_ram, one element at a time, ascending.
    task automatic model_op(input int md, input int s, input int d, input int n, input logic [31:0] f);
        int sa, da;
        if (m_reject(md, s, d) || n == 0) return;
        for (int i = 0; i < n; i++) begin
            if (md == 2) begin
                sa = (s + i) % 4096;
                da = (d + i) % 4096;
                exp_ram[da/4][8*(3-da%4) +: 8] = byte_of(exp_ram[sa/4], sa % 4);
            end else begin
                sa = (s + 4*i) % 4096;
                da = (d + 4*i) % 4096;
                exp_ram[da/4] = (md == 0) ? f : exp_ram[sa/4];
            end
        end
    endtask

    function automatic int m_done_cycle(input int md, input int s, input int d, input int n);
        if (m_reject(md, s, d) || n == 0) return 1;
        return (md == 0) ? n + 1 : 2*n + 1;
    endfunction

    function automatic int m_writes(input int md, input int s, input int d, input int n);
        if (m_reject(md, s, d)) return 0;
        return n;
    endfunction

    // Starts one operation and watches it cycle by cycle (cycle k = after edge k).
    // inj: 0 none, 1 abort at cycle inj_cyc, 2 competing start at cycle inj_cyc.
    task automatic run_op(input int md, input int s, input int d, input int n,
                          input logic [31:0] f, input bit abt_start,
                          input int inj, input int inj_cyc,
                          output int done_cyc, output logic err_at_done,
                          output int wrs, output logic busy_c1);
        int budget;
        budget = 2*n + 6;
        @(negedge clk);
        start = 1'b1; mode_i = 2'(md); src_i = 12'(s); dst_i = 12'(d);
        len_i = 10'(n); fill_i = f; abort = abt_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        done_cyc = 0; err_at_done = 1'b0; wrs = 0;
        busy_c1 = busy;
        for (int k = 1; k <= budget; k++) begin
            if (mem_if.m_wEn == WEN_WR) wrs++;
            if (done) begin
                done_cyc = k;
                err_at_done = err;
                break;
            end
            if (inj == 1 && k == inj_cyc) abort = 1'b1;
            if (inj == 2 && k == inj_cyc) begin
                start = 1'b1; mode_i = MODE_FILL; dst_i = 12'h300;
                len_i = 10'd4; fill_i = 32'hCAFEF00D;
            end
            @(negedge clk);
            abort = 1'b0; start = 1'b0;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  md;
        int          s, d, n;
        logic [31:0] f;
        bit          abt;
        bit          pre_en;
        logic [31:0] p0, p1, p2;
        bit          chk_en;
        int          chk_idx;
        logic [31:0] chk_val;
        int          exp_done;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] md, input int s, input int d, input int n,
                                input logic [31:0] f, input bit abt, input bit pre_en,
                                input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                input bit chk_en, input int chk_idx, input logic [31:0] chk_val,
                                input int exp_done, input logic exp_err, input int exp_wr);
        vec_t v;
        v.md = md; v.s = s; v.d = d; v.n = n; v.f = f; v.abt = abt;
        v.pre_en = pre_en; v.p0 = p0; v.p1 = p1; v.p2 = p2;
        v.chk_en = chk_en; v.chk_idx = chk_idx; v.chk_val = chk_val;
        v.exp_done = exp_done; v.exp_err = exp_err; v.exp_wr = exp_wr;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        int          dc, wr;
        logic        e, b1;
        int          md, s, d, n;
        logic [31:0] f;

        tbl[0] = mk(MODE_FILL, 'h000, 'h010, 4, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 4);
        tbl[1] = mk(MODE_CPW,  'h000, 'h040, 3, 32'h0, 0, 1, 32'h11111111, 32'h22222222, 32'h33333333,
                    1, 17, 32'h22222222, 7, 0, 3);
        tbl[2] = mk(MODE_CPB,  'h001, 'h006, 2, 32'h0, 0, 1, 32'hA1B2C3D4, 32'h0, 32'h0,
                    1, 1, 32'h0000B2C3, 5, 0, 2);
        tbl[3] = mk(MODE_FILL, 'h000, 'hFFC, 2, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A5A5A, 3, 0, 2);
        tbl[4] = mk(MODE_RSV,  'h000, 'h000, 4, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[5] = mk(MODE_CPW,  'h000, 'h002, 4, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[6] = mk(MODE_FILL, 'h000, 'h020, 0, 32'h77777777, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[7] = mk(MODE_FILL, 'h000, 'h080, 2, 32'h12345678, 1, 0, 0, 0, 0, 1, 33, 32'h12345678, 3, 0, 2);
        tbl[8] = mk(MODE_CPW,  'h001, 'h040, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[9] = mk(MODE_CPB,  'h0FF, 'h101, 5, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 0, 5);

        // reset values while rst is held low
        #1 rst = 1'b0;
        #2;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst wEn", 64'(mem_if.m_wEn), 64'(WEN_IDLE));
        check("rst addr", 64'(mem_if.m_addr), 64'd0);
        check("rst din", 64'(mem_if.m_din), 64'd0);
        check("rst byteExt", 64'(mem_if.m_byteExt), 64'(BX_W));
        for (int i = 0; i < 1024; i++) bd_write(i, $urandom);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].pre_en) begin
                bd_write(0, tbl[i].p0);
                bd_write(1, tbl[i].p1);
                bd_write(2, tbl[i].p2);
            end
            snapshot();
            model_op(tbl[i].md, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].f);
            run_op(tbl[i].md, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].f, tbl[i].abt, 0, 0, dc, e, wr, b1);
            check($sformatf("t%0d busy", i), 64'(b1), 64'd1);
            check($sformatf("t%0d done cycle", i), 64'(dc), 64'(tbl[i].exp_done));
            check($sformatf("t%0d err", i), 64'(e), 64'(tbl[i].exp_err));
            check($sformatf("t%0d writes", i), 64'(wr), 64'(tbl[i].exp_wr));
            compare_mem($sformatf("t%0d memory", i));
            if (tbl[i].chk_en)
                check($sformatf("t%0d word", i), 64'(ram[tbl[i].chk_idx]), 64'(tbl[i].chk_val));
        end

        // abort in the third FILL cycle of an 8-word fill
        snapshot();
        model_op(0, 0, 'h100, 3, 32'hABABABAB);
        run_op(0, 0, 'h100, 8, 32'hABABABAB, 0, 1, 3, dc, e, wr, b1);
        check("abort done", 64'(dc), 64'd0);
        check("abort writes", 64'(wr), 64'd3);
        check("abort busy", 64'(busy), 64'd0);
        compare_mem("abort memory");

        // start while busy is ignored
        snapshot();
        model_op(0, 0, 'h200, 4, 32'hAAAA5555);
        run_op(0, 0, 'h200, 4, 32'hAAAA5555, 0, 2, 2, dc, e, wr, b1);
        check("busy-start done", 64'(dc), 64'd5);
        check("busy-start writes", 64'(wr), 64'd4);
        wr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_if.m_wEn == WEN_WR || busy) wr++;
        end
        check("busy-start idle after", 64'(wr), 64'd0);
        compare_mem("busy-start memory");

        // abort in IDLE has no effect
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("idle abort busy", 64'(busy), 64'd0);

        // reset asserted mid-copy, during the second WR cycle
        snapshot();
        model_op(1, 0, 'h240, 1, 0);
        @(negedge clk);
        start = 1'b1; mode_i = MODE_CPW; src_i = 12'h000; dst_i = 12'h240; len_i = 10'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid rst pre wEn", 64'(mem_if.m_wEn), 64'(WEN_WR));
        #1 rst = 1'b0;
        #1;
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst wEn", 64'(mem_if.m_wEn), 64'(WEN_IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compare_mem("mid rst memory");

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            md = int'($urandom_range(0, 3));
            s  = int'($urandom_range(0, 4095));
            d  = int'($urandom_range(0, 4095));
            if (md != 2 && $urandom_range(0, 3) != 0) begin
                s = s & 'hFFC;
                d = d & 'hFFC;
            end
            n = int'($urandom_range(0, 12));
            f = $urandom;
            snapshot();
            model_op(md, s, d, n, f);
            run_op(md, s, d, n, f, 0, 0, 0, dc, e, wr, b1);
            check($sformatf("r%0d done cycle", i), 64'(dc), 64'(m_done_cycle(md, s, d, n)));
            check($sformatf("r%0d err", i), 64'(e), 64'(m_reject(md, s, d)));
            check($sformatf("r%0d writes", i), 64'(wr), 64'(m_writes(md, s, d, n)));
            compare_mem($sformatf("r%0d memory", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_block_mover.md
Name: dm_block_mover

Overview:
- Bus initiator for the 4 KB data memory: moves data across the memory's addr/din/byteExt/wEn/dout port without CPU involvement.
- Supports three operations: word fill, word copy and byte copy.
- Sits beside the CPU and is muxed onto the data-memory port while busy is high.
- The memory read path is combinational (dout follows addr in the same cycle); writes commit on posedge clk.
- Byte lanes are big-endian: byte offset 0 is bits [31:24].

Parameters:
- AW, 12, byte-address width of the memory port
- DW, 32, data width
- LW, 10, element-count width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- mode  in  2  00 fill word, 01 copy word, 10 copy byte, 11 reserved
- src_addr  in  AW  source byte address; latched on accepted start
- dst_addr  in  AW  destination byte address; latched on accepted start
- len  in  LW  element count (words or bytes); latched on accepted start
- fill_val  in  DW  fill pattern; latched on accepted start
- abort  in  1  terminate the current operation
- busy  out  1  high from the cycle after an accepted start through FIN inclusive
- done  out  1  one-cycle completion pulse, asserted in FIN
- err  out  1  qualifies done; high only in the FIN cycle of a rejected request
- m_addr  out  AW  memory byte address
- m_din  out  DW  memory write data
- m_byteExt  out  2  00 load byte unsigned, 01 load byte signed, 10 store byte, 11 word access
- m_wEn  out  2  01 write, 00 idle
- m_dout  in  DW  memory read data (combinational)

Behaviour:
- Reset (async, rst=0), all values:
  - state=IDLE, busy=0, done=0, err=0
  - m_wEn=00, m_addr=0, m_din=0, m_byteExt=11
  - internal counters and buffer cleared
- All outputs are Moore outputs decoded from registered state and datapath registers.
- m_wEn=01 only in the WR and FILL states.
- States: IDLE, RD, WR, FILL, FIN.
- IDLE, start=1 (edge 0) latches the operands, then:
  - mode=11 -> FIN with err.
  - Word mode with src_addr[1:0]!=0 (copy) or dst_addr[1:0]!=0 (fill or copy) -> FIN with err.
  - len=0 -> FIN, err=0, no memory write.
  - mode=00 -> FILL.
  - Otherwise -> RD.
- RD:
  - Drive m_addr=src, m_wEn=00.
  - m_byteExt=11 for word copy, 00 for byte copy.
  - Capture m_dout into buf at the clock edge (byte copy keeps m_dout[7:0]), then -> WR.
- WR:
  - Drive m_addr=dst, m_din=buf, m_wEn=01.
  - m_byteExt=11 for word copy, 10 for byte copy.
  - At the edge: src+=step, dst+=step, remaining-=1.
  - Next state: FIN if remaining was 1, else RD.
- FILL:
  - Drive m_addr=dst, m_din=fill_val, m_byteExt=11, m_wEn=01.
  - At the edge: dst+=4, remaining-=1.
  - Next state: FIN if remaining was 1, else stay in FILL.
- FIN: done=1, busy=1, m_wEn=00; -> IDLE unconditionally.
- Step size: 4 for word modes, 1 for byte copy.
- Address arithmetic is modulo 2^AW; 0xFFC+4 wraps to 0x000.
- Latency:
  - Copy of N elements: 2N cycles in RD/WR; done in cycle 2N+1 after the start edge.
  - Fill of N words: N cycles; done in cycle N+1.
  - Rejected request or len=0: done in cycle 1.
- start while busy is ignored, with no queuing.
- abort:
  - abort=1 in RD, WR or FILL -> IDLE at the next edge, no done pulse.
  - The write driven in that same cycle still commits.
  - abort in IDLE or FIN has no effect.
- start and abort both high in IDLE: start wins (abort is ignored in IDLE).
- Overlapping regions are copied in ascending order, one element at a time. memmove semantics are not provided.
- Reset asserted mid-operation returns to IDLE with m_wEn=00 immediately, without waiting for a clock edge.

Decomposition:
- Shared package dm_pkg holds:
  - mode codes MODE_FILL=2'b00, MODE_CPW=2'b01, MODE_CPB=2'b10
  - byteExt codes BX_LBU=2'b00, BX_LBS=2'b01, BX_SB=2'b10, BX_W=2'b11
  - WEN_WR=2'b01, WEN_IDLE=2'b00
  - the state encoding
- No sub-module: FSM, address counters and buffer stay in one module.
- A behavioural dm_4k model is instantiated only in the bench.

Test Plan:
- Fill: mode=00, dst=0x010, len=4, fill_val=0xDEADBEEF -> words 4..7 = 0xDEADBEEF; done exactly 5 cycles after the start edge; word 8 unchanged.
- Word copy: words 0..2 = 0x11111111/0x22222222/0x33333333; mode=01, src=0x000, dst=0x040, len=3 -> words 16..18 match; done at cycle 7; m_wEn=01 exactly 3 cycles.
- Byte copy: word 0=0xA1B2C3D4, word 1=0; mode=10, src=0x001, dst=0x006, len=2 -> word 1=0x0000B2C3; sign extension not applied to the stored data.
- Wrap: mode=00, dst=0xFFC, len=2, fill_val=0x5A5A5A5A -> words 1023 and 0 written; done at cycle 3.
- Errors: mode=11, or mode=01 with dst=0x002 -> done=1 and err=1 at cycle 1, no m_wEn=01 cycle; len=0 -> done=1, err=0 at cycle 1.
- Abort and reset:
  - abort in the third FILL cycle of len=8 -> exactly 3 words written, no done.
  - rst low mid-copy -> busy=0 and m_wEn=00 before the next edge.
  - start while busy -> ignored.
